pipe_reg_chain: RTL and testbench

//  Parametrised successor of the stall/flush pipeline register: a DEPTH-stage valid/ready

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_skid_buf.sv | 49 ++++
 rtl/pipe_reg_chain.sv | 144 ++++++++++++++
 tb/tb_pipe_reg_chain.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared entry type macro and width helper for the pipeline register chain
`define PIPE_ENTRY_T(W) struct packed { logic v; logic [(W)-1:0] d; }

package pipe_pkg;

    // Occupancy counts stages plus the optional skid entry, so it must reach DEPTH+1.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry input skid buffer with registered in_ready_o and flush
module pipe_skid_buf #(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             full_next_o
);

    typedef `PIPE_ENTRY_T(WIDTH) entry_t;

    entry_t slot_q;
    logic   ready_q;
    logic   in_fire;
    logic   capture;

    // While empty, the input bypasses the slot; the slot only catches a beat the
    // downstream side refuses, and it always drains before new input is taken.
    assign in_fire     = in_valid_i & ready_q;
    assign out_valid_o = slot_q.v | in_fire;
    assign out_data_o  = slot_q.v ? slot_q.d : in_data_i;
    assign full_next_o = !flush_i & out_valid_o & !out_ready_i;
    assign capture     = !slot_q.v & full_next_o;
    assign in_ready_o  = ready_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            slot_q.v <= full_next_o;
            ready_q  <= !full_next_o;
            if (capture) begin
                slot_q.d <= in_data_i;
            end else if (CLEAR_DATA && !full_next_o) begin
                slot_q.d <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/ready register chain with flush, kill and skid
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [WIDTH-1:0]            in_data_i,
    input  logic                        flush_i,
    input  logic [DEPTH-1:0]            kill_mask_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WIDTH-1:0]            out_data_o,
    output logic [occ_width(DEPTH)-1:0] occupancy_o
);

    typedef `PIPE_ENTRY_T(WIDTH) entry_t;
    localparam int OCC_W = occ_width(DEPTH);

    entry_t             stage_q [DEPTH];
    logic [DEPTH-1:0]   stage_v;
    logic [DEPTH-1:0]   ready;
    logic [DEPTH-1:0]   load;
    logic [DEPTH-1:0]   keep;
    logic [DEPTH-1:0]   nv;
    logic               feed_valid;
    logic [WIDTH-1:0]   feed_data;
    logic               skid_nv;
    logic [OCC_W-1:0]   occ_next;
    logic [OCC_W-1:0]   occ_q;

    // ready[k] = !v[k] | ready[k+1], unrolled so each bit only reads stage valids.
    always_comb begin
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ready[k] = out_ready_i;
            for (int j = k; j < DEPTH; j++) begin
                ready[k] = ready[k] | !stage_v[j];
            end
        end
    end

    if (SKID) begin : g_skid
        pipe_skid_buf #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_skid (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .flush_i     (flush_i),
            .in_valid_i  (in_valid_i),
            .in_ready_o  (in_ready_o),
            .in_data_i   (in_data_i),
            .out_valid_o (feed_valid),
            .out_ready_i (ready[0]),
            .out_data_o  (feed_data),
            .full_next_o (skid_nv)
        );
    end else begin : g_no_skid
        // Holds in_ready_o low for the first cycle after reset, matching the skid variant.
        logic live_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                live_q <= 1'b0;
            end else begin
                live_q <= 1'b1;
            end
        end

        assign in_ready_o = live_q & ready[0];
        assign feed_valid = in_valid_i & in_ready_o;
        assign feed_data  = in_data_i;
        assign skid_nv    = 1'b0;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        entry_t           q;
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic             dn_ready;

        if (k == 0) begin : g_head
            assign src_v = feed_valid;
            assign src_d = feed_data;
        end else begin : g_body
            assign src_v = stage_q[k-1].v & !kill_mask_i[k-1];
            assign src_d = stage_q[k-1].d;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready_i;
        end else begin : g_mid
            assign dn_ready = ready[k+1];
        end

        // A killed entry never stays; the stage is still free to load behind it.
        assign load[k] = !flush_i & src_v & ready[k];
        assign keep[k] = !flush_i & q.v & !kill_mask_i[k] & !dn_ready;
        assign nv[k]   = load[k] | keep[k];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                q <= '0;
            end else begin
                q.v <= nv[k];
                if (load[k]) begin
                    q.d <= src_d;
                end else if (CLEAR_DATA && !nv[k]) begin
                    q.d <= '0;
                end
            end
        end

        assign stage_q[k] = q;
        assign stage_v[k] = q.v;
    end

    always_comb begin
        occ_next = OCC_W'(skid_nv);
        for (int k = 0; k < DEPTH; k++) begin
            occ_next = occ_next + OCC_W'(nv[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_next;
        end
    end

    assign out_valid_o = stage_q[DEPTH-1].v;
    assign out_data_o  = stage_q[DEPTH-1].d;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   kill;
    logic [1:0]   occ;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(2), .SKID(1'b1), .CLEAR_DATA(1'b1)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .kill_mask_i (kill),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occ)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         fl;
        logic [1:0]   km;
        logic         ordy;
        logic         ir;
        logic         ov;
        logic [W-1:0] od;
        logic [1:0]   oc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int iv, input int id, input int fl, input int km,
                                input int ordy, input int ir, input int ov, input int od,
                                input int oc);
        vec_t v;
        v.iv = iv[0]; v.id = 16'(id); v.fl = fl[0]; v.km = 2'(km); v.ordy = ordy[0];
        v.ir = ir[0]; v.ov = ov[0]; v.od = 16'(od); v.oc = 2'(oc);
        return v;
    endfunction

    task automatic drive(input int iv, input int id, input int fl, input int km, input int ordy);
        in_valid  = iv[0];
        in_data   = 16'(id);
        flush     = fl[0];
        kill      = 2'(km);
        out_ready = ordy[0];
        @(posedge clk);
        #1;
    endtask

    localparam int NCFG = 6;

    for (genvar g = 0; g < NCFG; g++) begin : g_rand
        localparam int D  = (g < 2) ? 1 : (g < 4) ? 2 : 4;
        localparam bit S  = (g % 2) == 1;
        localparam int OW = $clog2(D + 2);

        bit            done = 1'b0;
        logic          r_rst_n, r_iv, r_ir, r_fl, r_ov, r_ordy;
        logic [W-1:0]  r_id, r_od;
        logic [D-1:0]  r_km;
        logic [OW-1:0] r_occ;

        pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .SKID(S), .CLEAR_DATA(1'b1)) u_dut (
            .clk_i       (clk),
            .rst_ni      (r_rst_n),
            .in_valid_i  (r_iv),
            .in_ready_o  (r_ir),
            .in_data_i   (r_id),
            .flush_i     (r_fl),
            .kill_mask_i (r_km),
            .out_valid_o (r_ov),
            .out_ready_i (r_ordy),
            .out_data_o  (r_od),
            .occupancy_o (r_occ)
        );

        initial begin
            int sent;
            int rcvd;
            int last_out;
            bit acc;
            bit hs;
            bit ok;
            sent = 0; rcvd = 0; last_out = -1;
            r_rst_n = 1'b0; r_iv = 1'b0; r_id = '0; r_fl = 1'b0; r_km = '0; r_ordy = 1'b0;
            wait (go);
            @(negedge clk);
            r_rst_n = 1'b1;
            for (int phase = 0; phase < 2; phase++) begin
                for (int c = 0; c < 350; c++) begin
                    @(negedge clk);
                    if (c < 300) begin
                        r_iv   = $urandom_range(0, 1) == 1;
                        r_ordy = $urandom_range(0, 3) != 0;
                        r_km   = (phase == 1 && $urandom_range(0, 5) == 0) ? D'($urandom) : '0;
                        r_fl   = phase == 1 && $urandom_range(0, 40) == 0;
                    end else begin
                        r_iv = 1'b0; r_ordy = 1'b1; r_km = '0; r_fl = 1'b0;
                    end
                    r_id = 16'(sent);
                    #1;
                    if (phase == 0) begin
                        check("rand_occ", 32'(r_occ), 32'(sent - rcvd));
                    end else begin
                        check("rand_occ_max", 32'(int'(r_occ) <= D + int'(S)), 32'd1);
                    end
                    acc = r_iv & r_ir & !r_fl;
                    hs  = r_ov & r_ordy & !r_km[D-1] & !r_fl;
                    if (hs) begin
                        if (phase == 0) begin
                            check("rand_order", 32'(r_od), 32'(16'(rcvd)));
                        end else begin
                            ok = int'(r_od) > last_out && int'(r_od) < sent;
                            check("rand_subseq", 32'(ok), 32'd1);
                        end
                        last_out = int'(r_od);
                        rcvd++;
                    end
                    if (acc) sent++;
                end
                if (phase == 0) check("rand_all_delivered", 32'(rcvd), 32'(sent));
            end
            done = 1'b1;
        end
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; kill = '0; out_ready = 1'b0;

        // streaming
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        vecs.push_back(mk(1, 'h01, 0, 0, 1,  1, 0, 'h00, 1));
        vecs.push_back(mk(1, 'h02, 0, 0, 1,  1, 1, 'h01, 2));
        vecs.push_back(mk(1, 'h03, 0, 0, 1,  1, 1, 'h02, 2));
        vecs.push_back(mk(1, 'h04, 0, 0, 1,  1, 1, 'h03, 2));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 1, 'h04, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        // stall fill into the skid, then release
        vecs.push_back(mk(1, 'h21, 0, 0, 0,  1, 0, 'h00, 1));
        vecs.push_back(mk(1, 'h22, 0, 0, 0,  1, 1, 'h21, 2));
        vecs.push_back(mk(1, 'h23, 0, 0, 0,  0, 1, 'h21, 3));
        vecs.push_back(mk(1, 'h24, 0, 0, 0,  0, 1, 'h21, 3));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 1, 'h22, 2));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 1, 'h23, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        // flush beats stall and drops the input beat
        vecs.push_back(mk(1, 'h31, 0, 0, 0,  1, 0, 'h00, 1));
        vecs.push_back(mk(1, 'h32, 0, 0, 0,  1, 1, 'h31, 2));
        vecs.push_back(mk(1, 'h33, 0, 0, 0,  0, 1, 'h31, 3));
        vecs.push_back(mk(1, 'hAA, 1, 0, 0,  1, 0, 'h00, 0));
        vecs.push_back(mk(1, 'hAB, 1, 0, 1,  1, 0, 'h00, 0));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        // kill stage 0 while it loads behind
        vecs.push_back(mk(1, 'h10, 0, 0, 1,  1, 0, 'h00, 1));
        vecs.push_back(mk(1, 'h11, 0, 0, 1,  1, 1, 'h10, 2));
        vecs.push_back(mk(1, 'h12, 0, 1, 1,  1, 0, 'h00, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 1, 'h12, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        // kill on the output stage, kill on an empty stage
        vecs.push_back(mk(1, 'h40, 0, 0, 1,  1, 0, 'h00, 1));
        vecs.push_back(mk(1, 'h41, 0, 0, 1,  1, 1, 'h40, 2));
        vecs.push_back(mk(0, 'h00, 0, 2, 1,  1, 1, 'h41, 1));
        vecs.push_back(mk(0, 'h00, 0, 1, 0,  1, 1, 'h41, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));
        // bubble collapse under stall
        vecs.push_back(mk(1, 'h05, 0, 0, 0,  1, 0, 'h00, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0,  1, 1, 'h05, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0,  1, 1, 'h05, 1));
        vecs.push_back(mk(1, 'h06, 0, 0, 0,  1, 1, 'h05, 2));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 1, 'h06, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1,  1, 0, 'h00, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({in_ready, out_valid, out_data, occ}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(int'(v.iv), int'(v.id), int'(v.fl), int'(v.km), int'(v.ordy));
            check($sformatf("vec%0d", i), 32'({in_ready, out_valid, out_data, occ}),
                  32'({v.ir, v.ov, v.od, v.oc}));
        end

        // reset while chain and skid are full
        drive(1, 'h61, 0, 0, 0);
        drive(1, 'h62, 0, 0, 0);
        drive(1, 'h63, 0, 0, 0);
        check("full_before_reset", 32'({in_ready, occ}), 32'({1'b0, 2'd3}));
        rst_n = 1'b0;
        drive(1, 'h64, 0, 0, 0);
        check("mid_reset_outputs", 32'({in_ready, out_valid, out_data, occ}), 32'd0);
        rst_n = 1'b1;
        drive(0, 'h00, 0, 0, 1);
        check("post_reset_ready", 32'({in_ready, out_valid, occ}), 32'({1'b1, 1'b0, 2'd0}));
        drive(1, 'h70, 0, 0, 1);
        drive(0, 'h00, 0, 0, 1);
        check("post_reset_stream", 32'({out_valid, out_data}), 32'({1'b1, 16'h0070}));

        go = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done &&
                g_rand[3].done && g_rand[4].done && g_rand[5].done) break;
            @(posedge clk);
        end
        check("rand_complete", 32'({g_rand[0].done, g_rand[1].done, g_rand[2].done,
                                    g_rand[3].done, g_rand[4].done, g_rand[5].done}),
              32'h3f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
